// File: rtl/spi_pio_bank_pkg.sv
// Shared constants and FSM state type for the SPI register bank.
package spi_pio_bank_pkg;

  localparam int ADDR_W     = 7;
  localparam int CMD_W      = 8;
  localparam int CMD_RD_BIT = 7;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } state_e;

endpackage

// File: rtl/spi_pio_sync.sv
// Two-flop synchroniser for one asynchronous SPI pin plus a third flop for
// rise/fall detection; RST_VAL sets the level all three flops reset to.
module spi_pio_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= {3{RST_VAL}};
    else       sync_q <= {sync_q[1:0], async_i};
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~sync_q[2];
  assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_pio_bank.sv
// Mode-0 SPI slave register bank: 8-bit command (rd + 7-bit addr) then
// DATA_W data bits. Define SPI_PIO_BANK_BURST_EN for auto-increment bursts.
module spi_pio_bank
  import spi_pio_bank_pkg::*;
#(
  parameter int              DATA_W    = 32,
  parameter int              NUM_REGS  = 2,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset,
  input  logic                         spi_sclk,
  input  logic                         spi_nss,
  input  logic                         spi_mosi,
  output logic                         spi_miso,
  output logic                         spi_miso_oe,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr
);

  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic nss_level, nss_rise, nss_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  spi_pio_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk_i(clk_clk), .rst_i(reset_reset), .async_i(spi_sclk),
    .level_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall));

  // nss resets high so an idle bus never shows a false select after reset.
  spi_pio_sync #(.RST_VAL(1'b1)) u_sync_nss (
    .clk_i(clk_clk), .rst_i(reset_reset), .async_i(spi_nss),
    .level_o(nss_level), .rise_o(nss_rise), .fall_o(nss_fall));

  spi_pio_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk_clk), .rst_i(reset_reset), .async_i(spi_mosi),
    .level_o(mosi_level), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused));

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0]       shift_q, shift_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    rd_q, rd_d;
  logic                    commit_d;
  logic [1:0]              settle_q;
  logic [DATA_W-1:0]       regs_q [NUM_REGS];
  logic                    wr_strobe_q;
  logic [ADDR_W-1:0]       wr_addr_q;

  logic [CMD_W-1:0]        cmd_word;
  logic [ADDR_W-1:0]       rd_addr;
  logic [DATA_W-1:0]       rd_word;
  logic                    nss_start;

  // A frame already running when reset drops shows its nss fall only while
  // the synchroniser is still flushing; that fall is ignored.
  assign nss_start = nss_fall && (settle_q == 2'd3);
  assign cmd_word  = {shift_q[CMD_W-2:0], mosi_level};
  assign rd_addr   = (state_q == CMD) ? cmd_word[ADDR_W-1:0] : addr_q + ADDR_W'(1);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < NUM_REGS_W;
  endfunction

  // Out-of-range addresses match no entry and so read as zero.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (rd_addr == ADDR_W'(k)) rd_word = regs_q[k];
  end

  // NOTE: every _d gets a default first so no path through the case can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    commit_d = 1'b0;
    case (state_q)
      IDLE: if (nss_start) begin
        state_d = CMD;
        cnt_d   = '0;
      end
      CMD: if (sclk_rise) begin
        shift_d = {shift_q[DATA_W-2:0], mosi_level};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(CMD_W-1)) begin
          state_d = DATA;
          cnt_d   = '0;
          addr_d  = cmd_word[ADDR_W-1:0];
          rd_d    = cmd_word[CMD_RD_BIT];
          shift_d = cmd_word[CMD_RD_BIT] ? rd_word : '0;
        end
      end
      DATA: begin
        if (sclk_rise) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!rd_q) shift_d = {shift_q[DATA_W-2:0], mosi_level};
          if (cnt_q == CNT_W'(DATA_W-1)) begin
            commit_d = !rd_q && in_range(addr_q);
            cnt_d    = '0;
`ifdef SPI_PIO_BANK_BURST_EN
            addr_d = addr_q + ADDR_W'(1);
            if (rd_q) shift_d = rd_word;
`else
            state_d = HOLD;
`endif
          end
        end else if (sclk_fall && rd_q && cnt_q != '0) begin
          // The MSB is already on MISO at load; shift only after a bit is taken.
          shift_d = {shift_q[DATA_W-2:0], 1'b0};
        end
      end
      HOLD: ;
      default: state_d = IDLE;
    endcase
    // The commit above is kept even when nss rises in the same cycle.
    if (nss_rise) state_d = IDLE;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      settle_q    <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      // NOTE: the bank is a handful of output flops, not a RAM, so each
      // entry is reset explicitly to RESET_VAL.
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= RESET_VAL;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      wr_strobe_q <= commit_d;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
      if (commit_d) begin
        wr_addr_q <= addr_q;
        for (int k = 0; k < NUM_REGS; k++)
          if (addr_q == ADDR_W'(k)) regs_q[k] <= shift_d;
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    assign reg_out[k*DATA_W +: DATA_W] = regs_q[k];
  end

  assign spi_miso    = (state_q == DATA) && rd_q && shift_q[DATA_W-1];
  assign spi_miso_oe = ~nss_level;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;

endmodule

// File: doc/spi_pio_bank.md
Name: spi_pio_bank

Overview:
- Parametrised SPI-slave register bank. It drives NUM_REGS output words of DATA_W bits each, replacing fixed pairs of 32-bit PIO outputs behind an SPI-to-Avalon bridge.
- Sits between the FX2LP SPI pins and DAC/control logic. It runs entirely in the fabric clock domain.
- Adds register readback, a per-write strobe, out-of-range protection and frame-abort handling.

Parameters:
- DATA_W, 32, width of each register and data phase in bits (8..32).
- NUM_REGS, 2, number of output registers (1..127).
- RESET_VAL, 0, reset value of every register (DATA_W bits).

Ports:
- clk_clk  input  1  fabric clock; must be >= 8x SCLK.
- reset_reset  input  1  synchronous, active-high reset.
- spi_sclk  input  1  SPI clock, asynchronous.
- spi_nss  input  1  SPI chip select, active low, asynchronous.
- spi_mosi  input  1  SPI data in, asynchronous.
- spi_miso  output  1  SPI data out.
- spi_miso_oe  output  1  MISO tristate enable; the top level builds the inout pad.
- reg_out  output  NUM_REGS*DATA_W  register contents, reg k at bits [k*DATA_W +: DATA_W].
- wr_strobe  output  1  one-cycle pulse on each committed write.
- wr_addr  output  7  address of the committed write, valid with wr_strobe.

Behaviour:
- Clock and reset: one clock, clk_clk. Reset is synchronous and active-high on reset_reset.
- Synchronisers: sclk, nss and mosi each pass through a 2-FF synchroniser. A third FF on sclk and nss provides edge detection.
- SPI mode: mode 0, MSB first. MOSI is sampled on a synced SCLK rise; MISO is updated on a synced SCLK fall.
- Frame format: nss low, then an 8-bit command, then DATA_W data bits.
  - Command bit7: 1 = read, 0 = write.
  - Command bits6:0: address.
- FSM states: IDLE, CMD, DATA, HOLD.
  - IDLE -> CMD on nss falling edge; bit counter cleared.
  - CMD -> DATA after the 8th rise; address and rw are latched.
  - DATA -> HOLD after DATA_W rises (non-burst).
  - HOLD ignores all further bits until nss rises.
  - Any state -> IDLE on nss rising edge.
- Write commit:
  - On the cycle after the last data rise, if addr < NUM_REGS: reg[addr] <= shifted word, and wr_strobe=1 with wr_addr=addr for one cycle.
  - If addr >= NUM_REGS: no register change and no strobe.
- Read:
  - At CMD->DATA, the shifter loads reg[addr], or 0 if addr >= NUM_REGS.
  - The MSB is driven on spi_miso immediately; subsequent bits shift out on each synced fall.
- spi_miso_oe: 1 whenever the synced nss is low; 0 otherwise.
- spi_miso value: 0 during CMD and during write frames.
- Abort: nss rising before the data phase completes returns to IDLE with no write and no strobe.
- Simultaneous events: a write commit and an nss rise in the same cycle still commit, because the last rise precedes nss high.
- Reset values (apply mid-frame too):
  - Every register = RESET_VAL.
  - wr_strobe = 0, wr_addr = 0, spi_miso = 0, spi_miso_oe = 0.
  - FSM = IDLE, counters = 0.
  - After reset, a frame already in progress is ignored until the next nss falling edge.
- Latency: reg_out updates 1 clk after the synced last data rise, about 4 clk after the pin edge.

Optional Feature:
- Macro: SPI_PIO_BANK_BURST_EN.
- Defined: after each DATA_W-bit word, DATA continues with addr+1, wrapping 127->0.
  - Each word commits or reads independently, with its own strobe and range check.
  - For reads, the shifter reloads from the new address at each word boundary.
- Undefined: one word per frame; extra bits are absorbed in HOLD.

Decomposition:
- Package spi_pio_bank_pkg:
  - ADDR_W=7, CMD_W=8.
  - state enum {IDLE, CMD, DATA, HOLD}.
  - CMD_RD_BIT=7.
- Sub-module spi_pio_sync: 2-FF synchroniser plus edge detect. It is instantiated for sclk, nss and mosi, and outputs level, rise and fall.

Test Plan:
- Reset: assert reset_reset 3 clk with defaults -> reg_out=0, spi_miso_oe=0, wr_strobe=0.
- Write: frame cmd 0x01, data 0xDEADBEEF -> reg1=0xDEADBEEF, reg0 unchanged, one wr_strobe with wr_addr=1.
- Read-back: write 0x12345678 to addr 0, then read frame cmd 0x80 -> MISO bits equal 0x12345678, spi_miso_oe high only while nss low.
- Out of range (NUM_REGS=2):
  - Write cmd 0x05, data 0xFFFFFFFF -> no reg change, no strobe.
  - Read cmd 0x85 -> MISO returns 0x00000000.
- Abort: write cmd 0x00, raise nss after 20 data bits -> reg0 unchanged, no strobe; the next full frame works.
- Burst (macro defined): cmd 0x00 with data 0xAAAAAAAA then 0x55555555 in one frame -> reg0=0xAAAAAAAA, reg1=0x55555555, two strobes with addr 0 then 1. Macro undefined -> only reg0 is written.
